axis_width_conv_ratio: RTL and testbench
========================================

// Module: axis_width_conv_ratio
// PURPOSE
//  Full-throughput AXI4-Stream width converter for any integer byte ratio, up or down, in one block.
//  Sits between the USB3.0 FIFO/DMA streams and the packet engines.
//  Supersedes the fixed-mode converter. Adds:
//   - back-to-back acceptance with no bubbles
//   - early-tlast padding
//   - trailing-null-slice trimming on downsize
//   - optional tid/tdest split.
// PARAMETERS
//  S_BYTES         4   input tdata width in bytes (1-512)
//  M_BYTES         16  output tdata width in bytes (1-512)
//                      One of S_BYTES/M_BYTES must divide the other; otherwise elaboration fails via $error.
//  TID_WIDTH       4   tid width, bits (1-32)
//  TDEST_WIDTH     4   tdest width, bits (1-32)
//  TUSER_PER_BYTE  1   tuser bits per tdata byte (1-64)
// PORTS
//  aclk           in   1                     clock
//  aresetn        in   1                     async reset, active-low
//  s_axis_tvalid  in   1                     input valid
//  s_axis_tready  out  1                     input ready
//  s_axis_tdata   in   S_BYTES*8             input data; byte 0 = lowest lane
//  s_axis_tstrb   in   S_BYTES               input strobe
//  s_axis_tkeep   in   S_BYTES               input keep
//  s_axis_tlast   in   1                     end of packet
//  s_axis_tid     in   TID_WIDTH             stream id
//  s_axis_tdest   in   TDEST_WIDTH           routing dest
//  s_axis_tuser   in   S_BYTES*TUSER_PER_BYTE  per-byte sideband
//  m_axis_*       mirror of s_axis_*, using M_BYTES; tvalid/tdata/... are outputs, tready is an input
// BEHAVIOUR
//  Reset: aresetn=0 forces m_axis_tvalid=0, m_axis_tlast=0 and s_axis_tready=0; clears lane counter and all state.
//   - Data registers need no reset.
//   - Reset asserted mid-packet drops the partial packet silently.
//   - First accept is possible in the first cycle after release.
//  Byte order: little-endian lanes. The earliest narrow beat maps to the lowest wide lanes.
//  Equal widths: pure wire passthrough, zero latency.
//  Upsize (R=M/S): accumulator plus output register.
//   - Lane index idx = 0..R-1. An accepted beat writes lanes [idx*S +: S] of tdata/tstrb/tkeep/tuser.
//   - Beat completes when idx==R-1 or s_tlast. The accumulator then moves to the output register on the next edge.
//   - Latency: 1 cycle from completing input beat to m_tvalid.
//   - idx resets to 0 on completion.
//   - Early tlast: unfilled lanes are driven tdata=0, tstrb=0, tkeep=0, tuser=0.
//   - tid/tdest come from the first beat of each output word.
//   - s_tready=0 only when a completed word waits in the accumulator and the output register is held (m_tvalid & !m_tready).
//   - Otherwise 1, giving 1 input beat per cycle sustained.
//  Downsize (R=S/M): one-beat holding register plus slice counter k.
//   - Output slice k carries bytes [k*M +: M]. Latency: m_tvalid rises 1 cycle after input accept.
//   - s_tready = !hold_valid | (m_tvalid & m_tready & last_slice). This is a combinational m_tready->s_tready path, which is permitted.
//   - Trim: on a tlast input beat, trailing slices whose tkeep is all zero are skipped.
//     m_tlast is asserted on the highest slice with any keep bit set.
//     If the whole beat has tkeep==0, slice 0 is emitted with tlast=1. tlast is never dropped.
//   - Non-tlast beats emit all R slices, null slices included.
//   - tid/tdest are held constant for all slices of a beat.
//  Handshake rules:
//   - m_tvalid never drops, and m_tdata/m_tkeep/m_tlast/m_tid never change, while m_tvalid=1 & m_tready=0.
//   - s_tvalid with s_tready=0 is not consumed.
//  Simultaneous input accept and output drain in the same cycle is required; no bubble is allowed.
// CONFIGURATION
//  AXIS_WCONV_ID_SPLIT_EN defined:
//   - Upsize: an input beat whose tid or tdest differs from the partially filled word closes that word first.
//     The closed word gets tlast=0, padded lanes keep=0. The new beat starts a fresh word at idx 0.
//   - Costs 1 stall cycle on s_tready.
//  Not defined: tid/tdest must be constant within a packet. A change mid-word is ignored; first-beat values win.
//  The downsize path is unaffected by the macro.
// TESTING
//  1. Up 4->16: 8 back-to-back beats 0x03020100..+0x04040404 with tlast on beat 8.
//     -> 2 words, first = 0x0F0E..00, tkeep=16'hFFFF, second tlast=1, zero input stalls.
//  2. Up 4->16, tlast on beat 2 (tkeep=4'hF).
//     -> one word, tkeep=16'h00FF, upper 8 bytes=0, tlast=1.
//  3. Down 16->4, tlast beat tkeep=16'h003F.
//     -> 2 slices, keep 4'hF then 4'h3, tlast on slice 2, slices 3-4 skipped.
//  4. Down 16->4, m_tready random 50%, 100 beats.
//     -> byte stream and tlast positions match the scoreboard, outputs stable while stalled.
//  5. Up 4->16, aresetn pulsed after beat 2 of 4.
//     -> no output word. The next packet's first word holds only post-reset bytes.
//  6. AXIS_WCONV_ID_SPLIT_EN, up 4->16, tid 1,1,2,2,2,2.
//     -> word tid=1 keep=16'h00FF tlast=0, then word tid=2 keep=16'hFFFF.

Source files
------------

// File: rtl/axis_width_conv_ratio.sv
// ---------------------------------------------------------------------------
// axis_width_conv_ratio
//
// Full-throughput AXI4-Stream width converter for any integer byte ratio.
// One of S_BYTES / M_BYTES must divide the other. Three build shapes:
//   equal widths : wire passthrough, zero latency
//   upsize       : lane accumulator + output register, one input beat/cycle,
//                  early-tlast words padded with zero data/strb/keep/user
//   downsize     : one-beat holding register + slice counter; trailing
//                  all-null slices of a tlast beat are trimmed
//
// Optional feature macro: AXIS_WCONV_ID_SPLIT_EN
//   Upsize only. A beat whose tid/tdest differs from the partially filled
//   word closes that word (tlast=0) first, costing one stall cycle.
//   Undefined: tid/tdest of the first beat of each word win.
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   s_axis_t{valid,ready,data,strb,keep,last,id,dest,user}  narrow/wide input
//   m_axis_t{valid,ready,data,strb,keep,last,id,dest,user}  converted output
//   Byte 0 is the lowest lane; earliest narrow beat maps to lowest wide lanes.
// ---------------------------------------------------------------------------
module axis_width_conv_ratio #(
    parameter int S_BYTES        = 4,
    parameter int M_BYTES        = 16,
    parameter int TID_WIDTH      = 4,
    parameter int TDEST_WIDTH    = 4,
    parameter int TUSER_PER_BYTE = 1
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [S_BYTES*8-1:0]                s_axis_tdata,
    input  logic [S_BYTES-1:0]                  s_axis_tstrb,
    input  logic [S_BYTES-1:0]                  s_axis_tkeep,
    input  logic                                s_axis_tlast,
    input  logic [TID_WIDTH-1:0]                s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]              s_axis_tdest,
    input  logic [S_BYTES*TUSER_PER_BYTE-1:0]   s_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [M_BYTES*8-1:0]                m_axis_tdata,
    output logic [M_BYTES-1:0]                  m_axis_tstrb,
    output logic [M_BYTES-1:0]                  m_axis_tkeep,
    output logic                                m_axis_tlast,
    output logic [TID_WIDTH-1:0]                m_axis_tid,
    output logic [TDEST_WIDTH-1:0]              m_axis_tdest,
    output logic [M_BYTES*TUSER_PER_BYTE-1:0]   m_axis_tuser
);

    localparam int SW = S_BYTES * 8;
    localparam int MW = M_BYTES * 8;
    localparam int SU = S_BYTES * TUSER_PER_BYTE;
    localparam int MU = M_BYTES * TUSER_PER_BYTE;

    generate
        if ((M_BYTES % S_BYTES != 0) && (S_BYTES % M_BYTES != 0)) begin : g_bad_ratio
            $error("axis_width_conv_ratio: S_BYTES and M_BYTES must divide one another");
        end

        if (S_BYTES == M_BYTES) begin : g_pass
            // Reset still has to hold both handshakes low.
            assign s_axis_tready = m_axis_tready & aresetn;
            assign m_axis_tvalid = s_axis_tvalid & aresetn;
            assign m_axis_tlast  = s_axis_tlast & aresetn;
            assign m_axis_tdata  = s_axis_tdata;
            assign m_axis_tstrb  = s_axis_tstrb;
            assign m_axis_tkeep  = s_axis_tkeep;
            assign m_axis_tid    = s_axis_tid;
            assign m_axis_tdest  = s_axis_tdest;
            assign m_axis_tuser  = s_axis_tuser;

        end else if (M_BYTES > S_BYTES) begin : g_up
            localparam int R  = M_BYTES / S_BYTES;
            localparam int IW = (R > 1) ? $clog2(R) : 1;

            logic [IW-1:0]          r_idx;
            logic                   r_acc_full;   // accumulator holds a finished word
            logic                   r_acc_last;
            logic [MW-1:0]          r_acc_data;
            logic [M_BYTES-1:0]     r_acc_strb, r_acc_keep;
            logic [MU-1:0]          r_acc_user;
            logic [TID_WIDTH-1:0]   r_acc_id;
            logic [TDEST_WIDTH-1:0] r_acc_dest;

            logic                   r_m_valid, r_m_last;
            logic [MW-1:0]          r_m_data;
            logic [M_BYTES-1:0]     r_m_strb, r_m_keep;
            logic [MU-1:0]          r_m_user;
            logic [TID_WIDTH-1:0]   r_m_id;
            logic [TDEST_WIDTH-1:0] r_m_dest;

            logic                   w_out_free, w_split, w_ready, w_accept, w_first, w_complete;
            logic [MW-1:0]          w_word_data;
            logic [M_BYTES-1:0]     w_word_strb, w_word_keep;
            logic [MU-1:0]          w_word_user;
            logic [TID_WIDTH-1:0]   w_word_id;
            logic [TDEST_WIDTH-1:0] w_word_dest;

`ifdef AXIS_WCONV_ID_SPLIT_EN
            // A partial word (idx != 0) is closed when the next beat changes stream.
            assign w_split = s_axis_tvalid & aresetn & (r_idx != '0) &
                             ((s_axis_tid != r_acc_id) | (s_axis_tdest != r_acc_dest));
`else
            assign w_split = 1'b0;
`endif

            assign w_out_free = ~r_m_valid | m_axis_tready;
            assign w_ready    = aresetn & ~(r_acc_full & ~w_out_free) & ~w_split;
            assign w_accept   = s_axis_tvalid & w_ready;
            assign w_first    = (r_idx == '0);
            assign w_complete = w_accept & (s_axis_tlast | (r_idx == IW'(R - 1)));

            // Word as it looks after the current beat lands. Starting each word
            // from zero is what pads the unfilled lanes of an early-tlast word.
            always_comb begin
                // NOTE: every always_comb output gets a default first, so no path can infer a latch.
                w_word_data = w_first ? '0 : r_acc_data;
                w_word_strb = w_first ? '0 : r_acc_strb;
                w_word_keep = w_first ? '0 : r_acc_keep;
                w_word_user = w_first ? '0 : r_acc_user;
                w_word_id   = w_first ? s_axis_tid   : r_acc_id;
                w_word_dest = w_first ? s_axis_tdest : r_acc_dest;
                w_word_data[r_idx*SW +: SW]             = s_axis_tdata;
                w_word_strb[r_idx*S_BYTES +: S_BYTES]   = s_axis_tstrb;
                w_word_keep[r_idx*S_BYTES +: S_BYTES]   = s_axis_tkeep;
                w_word_user[r_idx*SU +: SU]             = s_axis_tuser;
            end

            // NOTE: sequential state uses non-blocking assignments only; comb logic above uses blocking.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_idx      <= '0;
                    r_acc_full <= 1'b0;
                    r_m_valid  <= 1'b0;
                end else begin
                    if (w_out_free)
                        r_m_valid <= r_acc_full | w_complete | w_split;
                    if (w_accept) begin
                        r_idx      <= w_complete ? '0 : r_idx + IW'(1);
                        // A finished word stays in the accumulator only if the
                        // output register could not take it directly this edge.
                        r_acc_full <= w_complete & (r_acc_full | ~w_out_free);
                    end else if (w_split) begin
                        r_idx      <= '0;
                        r_acc_full <= ~w_out_free;
                    end else if (w_out_free) begin
                        r_acc_full <= 1'b0;
                    end
                end
            end

            // NOTE: datapath registers carry no reset; the valid flags above qualify them.
            always_ff @(posedge aclk) begin
                if (w_out_free) begin
                    // r_acc_last is already 0 on a split: the last beat taken did not complete.
                    if (r_acc_full | w_split) begin
                        r_m_data <= r_acc_data;
                        r_m_strb <= r_acc_strb;
                        r_m_keep <= r_acc_keep;
                        r_m_user <= r_acc_user;
                        r_m_id   <= r_acc_id;
                        r_m_dest <= r_acc_dest;
                        r_m_last <= r_acc_last;
                    end else if (w_complete) begin
                        r_m_data <= w_word_data;
                        r_m_strb <= w_word_strb;
                        r_m_keep <= w_word_keep;
                        r_m_user <= w_word_user;
                        r_m_id   <= w_word_id;
                        r_m_dest <= w_word_dest;
                        r_m_last <= s_axis_tlast;
                    end
                end
                if (w_accept) begin
                    r_acc_data <= w_word_data;
                    r_acc_strb <= w_word_strb;
                    r_acc_keep <= w_word_keep;
                    r_acc_user <= w_word_user;
                    r_acc_id   <= w_word_id;
                    r_acc_dest <= w_word_dest;
                    r_acc_last <= s_axis_tlast;
                end
            end

            assign s_axis_tready = w_ready;
            assign m_axis_tvalid = r_m_valid;
            assign m_axis_tlast  = r_m_valid & r_m_last;
            assign m_axis_tdata  = r_m_data;
            assign m_axis_tstrb  = r_m_strb;
            assign m_axis_tkeep  = r_m_keep;
            assign m_axis_tuser  = r_m_user;
            assign m_axis_tid    = r_m_id;
            assign m_axis_tdest  = r_m_dest;

        end else begin : g_down
            localparam int R  = S_BYTES / M_BYTES;
            localparam int KW = (R > 1) ? $clog2(R) : 1;

            logic                   r_h_valid, r_h_last;
            logic [KW-1:0]          r_k, r_last_k;
            logic [SW-1:0]          r_h_data;
            logic [S_BYTES-1:0]     r_h_strb, r_h_keep;
            logic [SU-1:0]          r_h_user;
            logic [TID_WIDTH-1:0]   r_h_id;
            logic [TDEST_WIDTH-1:0] r_h_dest;

            logic                   w_last_slice, w_drain, w_ready, w_accept;
            logic [KW-1:0]          w_trim_k;

            assign w_last_slice = (r_k == r_last_k);
            assign w_drain      = r_h_valid & m_axis_tready;
            // Refill in the same cycle the final slice leaves: no bubble.
            assign w_ready      = aresetn & (~r_h_valid | (w_drain & w_last_slice));
            assign w_accept     = s_axis_tvalid & w_ready;

            // Index of the final slice to emit: the highest slice with any keep
            // bit on a tlast beat (slice 0 if none), otherwise every slice.
            always_comb begin
                w_trim_k = KW'(R - 1);
                if (s_axis_tlast) begin
                    w_trim_k = '0;
                    for (int j = 0; j < R; j++)
                        if (|s_axis_tkeep[j*M_BYTES +: M_BYTES])
                            w_trim_k = KW'(j);
                end
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_h_valid <= 1'b0;
                    r_k       <= '0;
                end else if (w_accept) begin
                    r_h_valid <= 1'b1;
                    r_k       <= '0;
                end else if (w_drain) begin
                    if (w_last_slice)
                        r_h_valid <= 1'b0;
                    else
                        r_k <= r_k + KW'(1);
                end
            end

            always_ff @(posedge aclk) begin
                if (w_accept) begin
                    r_h_data <= s_axis_tdata;
                    r_h_strb <= s_axis_tstrb;
                    r_h_keep <= s_axis_tkeep;
                    r_h_user <= s_axis_tuser;
                    r_h_id   <= s_axis_tid;
                    r_h_dest <= s_axis_tdest;
                    r_h_last <= s_axis_tlast;
                    r_last_k <= w_trim_k;
                end
            end

            assign s_axis_tready = w_ready;
            assign m_axis_tvalid = r_h_valid;
            assign m_axis_tlast  = r_h_valid & r_h_last & w_last_slice;
            assign m_axis_tdata  = r_h_data[r_k*MW +: MW];
            assign m_axis_tstrb  = r_h_strb[r_k*M_BYTES +: M_BYTES];
            assign m_axis_tkeep  = r_h_keep[r_k*M_BYTES +: M_BYTES];
            assign m_axis_tuser  = r_h_user[r_k*MU +: MU];
            assign m_axis_tid    = r_h_id;
            assign m_axis_tdest  = r_h_dest;
        end
    endgenerate

endmodule

// File: tb/tb_axis_width_conv_ratio.sv
// ---------------------------------------------------------------------------
// tb_axis_width_conv_ratio
//
// Two instances: 4->16 upsize and 16->4 downsize. A queue-based packet model
// turns every accepted input beat into the output beats it must produce; one
// negedge monitor compares each output handshake against the model and checks
// that a stalled output holds. Directed cases pin the model with literals.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_width_conv_ratio;

`ifdef AXIS_WCONV_ID_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  strb;
        logic [15:0]  keep;
        logic [15:0]  user;
        logic         last;
        logic [3:0]   id;
        logic [3:0]   dest;
    } beat_t;

    logic aclk, aresetn;

    // upsize 4 -> 16
    logic         u_s_valid, u_s_ready, u_s_last;
    logic [31:0]  u_s_data;
    logic [3:0]   u_s_strb, u_s_keep, u_s_id, u_s_dest, u_s_user;
    logic         u_m_valid, u_m_ready, u_m_last;
    logic [127:0] u_m_data;
    logic [15:0]  u_m_strb, u_m_keep, u_m_user;
    logic [3:0]   u_m_id, u_m_dest;

    // downsize 16 -> 4
    logic         d_s_valid, d_s_ready, d_s_last;
    logic [127:0] d_s_data;
    logic [15:0]  d_s_strb, d_s_keep, d_s_user;
    logic [3:0]   d_s_id, d_s_dest;
    logic         d_m_valid, d_m_ready, d_m_last;
    logic [31:0]  d_m_data;
    logic [3:0]   d_m_strb, d_m_keep, d_m_user, d_m_id, d_m_dest;

    axis_width_conv_ratio #(.S_BYTES(4), .M_BYTES(16), .TID_WIDTH(4), .TDEST_WIDTH(4), .TUSER_PER_BYTE(1)) u_up (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(u_s_valid), .s_axis_tready(u_s_ready), .s_axis_tdata(u_s_data),
        .s_axis_tstrb(u_s_strb), .s_axis_tkeep(u_s_keep), .s_axis_tlast(u_s_last),
        .s_axis_tid(u_s_id), .s_axis_tdest(u_s_dest), .s_axis_tuser(u_s_user),
        .m_axis_tvalid(u_m_valid), .m_axis_tready(u_m_ready), .m_axis_tdata(u_m_data),
        .m_axis_tstrb(u_m_strb), .m_axis_tkeep(u_m_keep), .m_axis_tlast(u_m_last),
        .m_axis_tid(u_m_id), .m_axis_tdest(u_m_dest), .m_axis_tuser(u_m_user)
    );

    axis_width_conv_ratio #(.S_BYTES(16), .M_BYTES(4), .TID_WIDTH(4), .TDEST_WIDTH(4), .TUSER_PER_BYTE(1)) u_dn (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(d_s_valid), .s_axis_tready(d_s_ready), .s_axis_tdata(d_s_data),
        .s_axis_tstrb(d_s_strb), .s_axis_tkeep(d_s_keep), .s_axis_tlast(d_s_last),
        .s_axis_tid(d_s_id), .s_axis_tdest(d_s_dest), .s_axis_tuser(d_s_user),
        .m_axis_tvalid(d_m_valid), .m_axis_tready(d_m_ready), .m_axis_tdata(d_m_data),
        .m_axis_tstrb(d_m_strb), .m_axis_tkeep(d_m_keep), .m_axis_tlast(d_m_last),
        .m_axis_tid(d_m_id), .m_axis_tdest(d_m_dest), .m_axis_tuser(d_m_user)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    int up_stalls = 0;
    bit u_rdy_rand = 1'b0;
    bit d_rdy_rand = 1'b0;

    beat_t up_exp[$], up_log[$], dn_exp[$], dn_log[$];
    beat_t up_part;
    int    up_n = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Upsize packing rule: fill 4-byte lanes low to high, close on 4 lanes or
    // tlast (and, with the split build, on a tid/tdest change).
    function automatic void up_model(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                                     input logic [3:0] u, input logic l, input logic [3:0] id,
                                     input logic [3:0] de);
        if (SPLIT && up_n != 0 && (id != up_part.id || de != up_part.dest)) begin
            up_exp.push_back(up_part);
            up_n = 0;
        end
        if (up_n == 0) begin
            up_part      = '0;
            up_part.id   = id;
            up_part.dest = de;
        end
        up_part.data[up_n*32 +: 32] = d;
        up_part.strb[up_n*4 +: 4]   = s;
        up_part.keep[up_n*4 +: 4]   = k;
        up_part.user[up_n*4 +: 4]   = u;
        up_n++;
        if (up_n == 4 || l) begin
            up_part.last = l;
            up_exp.push_back(up_part);
            up_n = 0;
        end
    endfunction

    // Downsize slicing rule: 4 slices, but a tlast beat stops at the highest
    // slice holding a keep bit (at least one slice).
    function automatic void dn_model(input logic [127:0] d, input logic [15:0] s, input logic [15:0] k,
                                     input logic [15:0] u, input logic l, input logic [3:0] id,
                                     input logic [3:0] de);
        int n;
        beat_t b;
        n = 4;
        if (l) begin
            n = 1;
            for (int j = 0; j < 4; j++)
                if (k[j*4 +: 4] != 4'h0) n = j + 1;
        end
        for (int j = 0; j < n; j++) begin
            b = '0;
            b.data[31:0] = d[j*32 +: 32];
            b.strb[3:0]  = s[j*4 +: 4];
            b.keep[3:0]  = k[j*4 +: 4];
            b.user[3:0]  = u[j*4 +: 4];
            b.last       = l && (j == n - 1);
            b.id         = id;
            b.dest       = de;
            dn_exp.push_back(b);
        end
    endfunction

    function automatic beat_t up_at(input int i);
        return (i < up_log.size()) ? up_log[i] : beat_t'('0);
    endfunction

    function automatic beat_t dn_at(input int i);
        return (i < dn_log.size()) ? dn_log[i] : beat_t'('0);
    endfunction

    // Ready generators: always 1, or a 50% coin per cycle.
    initial begin
        u_m_ready = 1'b1;
        d_m_ready = 1'b1;
    end
    always @(posedge aclk) begin
        #1;
        u_m_ready = u_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        d_m_ready = d_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor / comparator: all signals are stable at the negedge.
    beat_t u_cur, u_prev, d_cur, d_prev;
    bit    u_held = 1'b0;
    bit    d_held = 1'b0;
    always @(negedge aclk) begin
        u_cur = {u_m_data, u_m_strb, u_m_keep, u_m_user, u_m_last, u_m_id, u_m_dest};
        d_cur = {96'h0, d_m_data, 12'h0, d_m_strb, 12'h0, d_m_keep, 12'h0, d_m_user, d_m_last, d_m_id, d_m_dest};
        if (!aresetn) begin
            up_exp.delete();
            dn_exp.delete();
            up_n   = 0;
            u_held = 1'b0;
            d_held = 1'b0;
        end else begin
            if (u_s_valid && u_s_ready)
                up_model(u_s_data, u_s_strb, u_s_keep, u_s_user, u_s_last, u_s_id, u_s_dest);
            if (d_s_valid && d_s_ready)
                dn_model(d_s_data, d_s_strb, d_s_keep, d_s_user, d_s_last, d_s_id, d_s_dest);

            if (u_held) begin
                check("up_hold_valid", u_m_valid, 1'b1);
                check("up_hold_beat", u_cur, u_prev);
            end
            if (u_m_valid && u_m_ready) begin
                up_log.push_back(u_cur);
                if (up_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL up_extra: got %0h, expected no output word", u_cur);
                end else begin
                    check("up_word", u_cur, up_exp.pop_front());
                end
            end
            u_held = u_m_valid && !u_m_ready;
            u_prev = u_cur;

            if (d_held) begin
                check("dn_hold_valid", d_m_valid, 1'b1);
                check("dn_hold_beat", d_cur, d_prev);
            end
            if (d_m_valid && d_m_ready) begin
                dn_log.push_back(d_cur);
                if (dn_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dn_extra: got %0h, expected no output slice", d_cur);
                end else begin
                    check("dn_slice", d_cur, dn_exp.pop_front());
                end
            end
            d_held = d_m_valid && !d_m_ready;
            d_prev = d_cur;
        end
    end

    // Drivers: called just after a posedge, return just after the accepting edge.
    task automatic up_send(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [3:0] id, input logic [3:0] de);
        bit done;
        u_s_valid = 1'b1; u_s_data = d; u_s_keep = k; u_s_strb = k;
        u_s_last = l; u_s_id = id; u_s_dest = de; u_s_user = 4'($urandom);
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge aclk);
            done = u_s_ready;
            if (!done) up_stalls++;
            @(posedge aclk); #1;
        end
        u_s_valid = 1'b0;
        if (!done) check("up_send_timeout", done, 1'b1);
    endtask

    task automatic dn_send(input logic [127:0] d, input logic [15:0] k, input logic l,
                           input logic [3:0] id, input logic [3:0] de);
        bit done;
        d_s_valid = 1'b1; d_s_data = d; d_s_keep = k; d_s_strb = k;
        d_s_last = l; d_s_id = id; d_s_dest = de; d_s_user = 16'($urandom);
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge aclk);
            done = d_s_ready;
            @(posedge aclk); #1;
        end
        d_s_valid = 1'b0;
        if (!done) check("dn_send_timeout", done, 1'b1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000; t++) begin
            if (up_exp.size() == 0 && dn_exp.size() == 0 && !u_m_valid && !d_m_valid) break;
            @(posedge aclk); #1;
        end
        check("drain_up", up_exp.size(), 0);
        check("drain_dn", dn_exp.size(), 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] dd;
        logic [3:0]   pid;
        logic [15:0]  kk;
        beat_t        b0, b1;

        aresetn = 1'b0;
        u_s_valid = 1'b0; u_s_data = '0; u_s_strb = '0; u_s_keep = '0;
        u_s_last = 1'b0; u_s_id = '0; u_s_dest = '0; u_s_user = '0;
        d_s_valid = 1'b0; d_s_data = '0; d_s_strb = '0; d_s_keep = '0;
        d_s_last = 1'b0; d_s_id = '0; d_s_dest = '0; d_s_user = '0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_up_s_ready", u_s_ready, 1'b0);
        check("rst_up_m_valid", u_m_valid, 1'b0);
        check("rst_up_m_last",  u_m_last,  1'b0);
        check("rst_dn_s_ready", d_s_ready, 1'b0);
        check("rst_dn_m_valid", d_m_valid, 1'b0);
        check("rst_dn_m_last",  d_m_last,  1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_up_ready", u_s_ready, 1'b1);
        check("post_rst_dn_ready", d_s_ready, 1'b1);
        @(posedge aclk); #1;

        // 1: eight back-to-back beats -> two full words, no input stall
        up_log.delete(); up_stalls = 0;
        for (int i = 0; i < 8; i++)
            up_send(32'h03020100 + 32'(i) * 32'h04040404, 4'hF, i == 7, 4'h1, 4'h2);
        wait_drain();
        b0 = up_at(0); b1 = up_at(1);
        check("t1_words",   up_log.size(), 2);
        check("t1_w0_data", b0.data, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t1_w0_keep", b0.keep, 16'hFFFF);
        check("t1_w0_last", b0.last, 1'b0);
        check("t1_w1_data", b1.data, 128'h1F1E1D1C1B1A19181716151413121110);
        check("t1_w1_last", b1.last, 1'b1);
        check("t1_stalls",  up_stalls, 0);

        // 2: tlast on beat 2 -> padded word
        up_log.delete();
        up_send(32'hDDCCBBAA, 4'hF, 1'b0, 4'h3, 4'h4);
        up_send(32'h44332211, 4'hF, 1'b1, 4'h3, 4'h4);
        wait_drain();
        b0 = up_at(0);
        check("t2_words",   up_log.size(), 1);
        check("t2_data",    b0.data, 128'h00000000_00000000_44332211_DDCCBBAA);
        check("t2_keep",    b0.keep, 16'h00FF);
        check("t2_strb",    b0.strb, 16'h00FF);
        check("t2_last",    b0.last, 1'b1);
        check("t2_id",      b0.id, 4'h3);

        // 5: reset after beat 2 of 4 drops the partial packet
        up_log.delete();
        up_send(32'hEEEEEEEE, 4'hF, 1'b0, 4'h1, 4'h1);
        up_send(32'hFFFFFFFF, 4'hF, 1'b0, 4'h1, 4'h1);
        aresetn = 1'b0;
        @(negedge aclk);
        check("t5_rst_ready", u_s_ready, 1'b0);
        check("t5_rst_valid", u_m_valid, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++)
            up_send(32'hA0A1A2A3 + 32'(i), 4'hF, i == 3, 4'h5, 4'h6);
        wait_drain();
        b0 = up_at(0);
        check("t5_words", up_log.size(), 1);
        check("t5_data",  b0.data, 128'hA0A1A2A6_A0A1A2A5_A0A1A2A4_A0A1A2A3);
        check("t5_last",  b0.last, 1'b1);

        // 6: tid 1,1,2,2,2,2
        up_log.delete();
        for (int i = 0; i < 6; i++)
            up_send({4{8'(i + 1)}}, 4'hF, i == 5, (i < 2) ? 4'h1 : 4'h2, 4'h0);
        wait_drain();
        b0 = up_at(0); b1 = up_at(1);
        check("t6_words",   up_log.size(), 2);
        check("t6_w0_id",   b0.id, 4'h1);
        check("t6_w0_last", b0.last, 1'b0);
        check("t6_w1_id",   b1.id, 4'h2);
        check("t6_w1_last", b1.last, 1'b1);
`ifdef AXIS_WCONV_ID_SPLIT_EN
        check("t6_w0_keep", b0.keep, 16'h00FF);
        check("t6_w0_data", b0.data, 128'h0202020201010101);
        check("t6_w1_keep", b1.keep, 16'hFFFF);
`else
        check("t6_w0_keep", b0.keep, 16'hFFFF);
        check("t6_w0_data", b0.data, 128'h04040404030303030202020201010101);
        check("t6_w1_keep", b1.keep, 16'h00FF);
`endif

        // Random upsize traffic with 50% output backpressure
        u_rdy_rand = 1'b1;
        pid = 4'h7;
        for (int i = 0; i < 60; i++) begin
            logic l;
            if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
            l = ($urandom_range(0, 4) == 0);
            up_send($urandom, 4'($urandom), l, pid, ~pid);
            if (l) pid = 4'($urandom);
        end
        up_send($urandom, 4'hF, 1'b1, pid, ~pid);
        wait_drain();
        u_rdy_rand = 1'b0;

        // 3: trimmed tlast beat, keep 003F -> 2 slices
        dn_log.delete();
        dd = rnd128();
        dn_send(dd, 16'h003F, 1'b1, 4'h5, 4'h6);
        wait_drain();
        b0 = dn_at(0); b1 = dn_at(1);
        check("t3_slices",  dn_log.size(), 2);
        check("t3_s0_keep", b0.keep, 16'h000F);
        check("t3_s0_last", b0.last, 1'b0);
        check("t3_s1_keep", b1.keep, 16'h0003);
        check("t3_s1_data", b1.data, {96'h0, dd[63:32]});
        check("t3_s1_last", b1.last, 1'b1);
        check("t3_s1_id",   b1.id, 4'h5);

        // All-null tlast beat -> slice 0 only, tlast kept
        dn_log.delete();
        dd = rnd128();
        dn_send(dd, 16'h0000, 1'b1, 4'h2, 4'h3);
        wait_drain();
        b0 = dn_at(0);
        check("tz_slices", dn_log.size(), 1);
        check("tz_data",   b0.data, {96'h0, dd[31:0]});
        check("tz_keep",   b0.keep, 16'h0000);
        check("tz_last",   b0.last, 1'b1);

        // Non-tlast beat keeps its null slices
        dn_log.delete();
        dn_send(rnd128(), 16'h0F00, 1'b0, 4'h1, 4'h1);
        dn_send(rnd128(), 16'hFFFF, 1'b1, 4'h1, 4'h1);
        wait_drain();
        check("tn_slices",  dn_log.size(), 8);
        check("tn_s0_keep", dn_at(0).keep, 16'h0000);
        check("tn_s3_last", dn_at(3).last, 1'b0);
        check("tn_s7_last", dn_at(7).last, 1'b1);

        // 4: 100 random beats, 50% output backpressure
        d_rdy_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(0, 2))
                0:       kk = 16'hFFFF;
                1:       kk = 16'($urandom);
                default: kk = 16'hFFFF >> (4 * $urandom_range(0, 4));
            endcase
            if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
            dn_send(rnd128(), kk, $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom));
        end
        wait_drain();
        d_rdy_rand = 1'b0;

        repeat (4) @(posedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
